// File: rtl/router_pkg.sv
// Shared router definitions: port count, address width and the queued entry layout.
package router_pkg;

    localparam int unsigned ADDR_W       = 2;
    localparam int unsigned NUM_PORTS    = 4;
    localparam int unsigned ROUTE_DATA_W = 32;

    // One queued word together with its destination port.
    typedef struct packed {
        logic [ADDR_W-1:0]       addr;
        logic [ROUTE_DATA_W-1:0] data;
    } route_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage array, wrapping pointers, occupancy and full/empty flags.
module sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Guard against overflow/underflow regardless of what the caller requests.
    always_comb begin
        o_full  = (r_count == CNT_W'(DEPTH));
        o_empty = (r_count == '0);
        w_push  = i_push & ~o_full;
        w_pop   = i_pop & ~o_empty;
        o_rdata = r_mem[r_rptr];
        o_count = r_count;
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/router_ingress_queue.sv
// Ingress buffer ahead of the router: queues addressed words and replays them through
// a zeroing output register, one word per unstalled cycle.
module router_ingress_queue
    import router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic                  out_stall,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  din_en,
    output logic [ADDR_W-1:0]     addr,
    output logic [CNT_W-1:0]      count
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_WIDTH;

    logic [ENTRY_W-1:0]    w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] r_din;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_din_en;

    // Handshake and pop decisions depend only on current occupancy and the stall input.
    always_comb begin
        in_ready = ~w_full;
        w_push   = in_valid & ~w_full;
        w_pop    = ~w_empty & ~out_stall;
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({in_addr, in_data}),
        .o_rdata (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Output stage: present the head word on a pop, otherwise drive all zeros.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_din    <= '0;
            r_addr   <= '0;
            r_din_en <= 1'b0;
        end else if (w_pop) begin
            r_din    <= w_head[DATA_WIDTH-1:0];
            r_addr   <= w_head[ENTRY_W-1:DATA_WIDTH];
            r_din_en <= 1'b1;
        end else begin
            r_din    <= '0;
            r_addr   <= '0;
            r_din_en <= 1'b0;
        end
    end

    assign din    = r_din;
    assign addr   = r_addr;
    assign din_en = r_din_en;

endmodule
